// File: rtl/tdm_demux_if.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_if
//  Purpose  : Bundles the serial input side and the parallel output side of
//             the TDM receive demultiplexer.
//  Signals  : din, frame, en, clr_err       driven by the link side (master)
//             q, sel, frame_valid, sync_err  driven by the demux (slave)
//             par_err                        only with TDM_DEMUX_PARITY_EN
//  Config   : TDM_DEMUX_PARITY_EN adds the parity slot and the par_err signal
//  Revision : 1.0  initial release
// ============================================================================
interface tdm_demux_if #(
  parameter int N_CH = 4
);
`ifdef TDM_DEMUX_PARITY_EN
  // The parity slot makes the frame one bit longer, so the slot index must
  // be able to reach N_CH.
  localparam int c_len = N_CH + 1;
`else
  localparam int c_len = N_CH;
`endif
  localparam int SW = $clog2(c_len);

  logic            din;
  logic            frame;
  logic            en;
  logic            clr_err;
  logic [N_CH-1:0] q;
  logic [SW-1:0]   sel;
  logic            frame_valid;
  logic            sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic            par_err;

  modport master (
    output din, frame, en, clr_err,
    input  q, sel, frame_valid, sync_err, par_err
  );
  modport slave (
    input  din, frame, en, clr_err,
    output q, sel, frame_valid, sync_err, par_err
  );
`else
  modport master (
    output din, frame, en, clr_err,
    input  q, sel, frame_valid, sync_err
  );
  modport slave (
    input  din, frame, en, clr_err,
    output q, sel, frame_valid, sync_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux
//  Purpose  : Receive end of a 1-bit time-division-multiplexed link. Locks to
//             the frame marker, steers each strobed bit into its channel slot
//             and presents all N_CH channels in parallel once per frame.
//  Ports    : clk    system clock, rising edge
//             reset  asynchronous, active-high
//             bus    tdm_demux_if.slave
//                      in : din, frame, en, clr_err
//                      out: q, sel, frame_valid, sync_err (, par_err)
//  Params   : N_CH   channels per frame, 2..16
//  Config   : TDM_DEMUX_PARITY_EN  appends an even-parity slot to each frame;
//             a frame failing parity is dropped and par_err pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux #(
  parameter int N_CH = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  tdm_demux_if.slave bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int c_len = N_CH + 1;
`else
  localparam int c_len = N_CH;
`endif
  localparam int c_sw = $clog2(c_len);
  localparam int c_iw = $clog2(N_CH);
  localparam logic [c_sw-1:0] c_one  = c_sw'(1);
  localparam logic [c_sw-1:0] c_last = c_sw'(c_len - 1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          r_state, w_state_nx;
  logic [N_CH-1:0] r_shadow, w_shadow_nx;
  logic [N_CH-1:0] r_q, w_q_nx;
  logic [c_sw-1:0] r_sel, w_sel_nx;
  logic            r_fv, w_fv_nx;
  logic            r_serr, w_serr_nx;
  logic            w_fault;
`ifdef TDM_DEMUX_PARITY_EN
  logic            r_perr, w_perr_nx;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= HUNT;
      r_shadow <= '0;
      r_q      <= '0;
      r_sel    <= '0;
      r_fv     <= 1'b0;
      r_serr   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_perr   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_shadow <= w_shadow_nx;
      r_q      <= w_q_nx;
      r_sel    <= w_sel_nx;
      r_fv     <= w_fv_nx;
      r_serr   <= w_serr_nx;
`ifdef TDM_DEMUX_PARITY_EN
      r_perr   <= w_perr_nx;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx  = r_state;
    w_shadow_nx = r_shadow;
    w_q_nx      = r_q;
    w_sel_nx    = r_sel;
    w_fv_nx     = 1'b0;
    w_fault     = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    w_perr_nx   = 1'b0;
`endif

    if (bus.en) begin
      case (r_state)
        HUNT: begin
          if (bus.frame) begin
            w_shadow_nx[0] = bus.din;
            w_sel_nx       = c_one;
            w_state_nx     = LOCK;
          end
        end

        LOCK: begin
          if (bus.frame) begin
            // A marker anywhere but slot 0 is a framing fault; either way the
            // marker bit starts a fresh frame so we resynchronise at once.
            if (r_sel != '0) begin
              w_fault = 1'b1;
            end
            w_shadow_nx[0] = bus.din;
            w_sel_nx       = c_one;
          end else if (r_sel == '0) begin
            // Marker missing where slot 0 was due: lost sync, drop the bit.
            w_fault    = 1'b1;
            w_state_nx = HUNT;
          end else if (r_sel == c_last) begin
            w_sel_nx = '0;
`ifdef TDM_DEMUX_PARITY_EN
            // Last bit is the even-parity bit over all channel bits.
            if (^{bus.din, r_shadow}) begin
              w_perr_nx = 1'b1;
            end else begin
              w_q_nx  = r_shadow;
              w_fv_nx = 1'b1;
            end
`else
            // The final channel bit goes straight to q so the frame is
            // presented on the same edge that samples it.
            w_q_nx  = {bus.din, r_shadow[N_CH-2:0]};
            w_fv_nx = 1'b1;
`endif
          end else begin
            w_shadow_nx[r_sel[c_iw-1:0]] = bus.din;
            w_sel_nx                     = r_sel + c_one;
          end
        end

        default: begin
          w_state_nx = HUNT;
        end
      endcase
    end

    // A fault in the same cycle as a clear keeps the flag set.
    if (w_fault) begin
      w_serr_nx = 1'b1;
    end else if (bus.clr_err) begin
      w_serr_nx = 1'b0;
    end else begin
      w_serr_nx = r_serr;
    end
  end

  assign bus.q           = r_q;
  assign bus.sel         = r_sel;
  assign bus.frame_valid = r_fv;
  assign bus.sync_err    = r_serr;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err     = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux
//  Purpose  : Self-checking bench for tdm_demux (N_CH=4): directed vector
//             table, async-reset and parity sequences, and randomized traffic
//             against a queue-based frame model.
//  Config   : TDM_DEMUX_PARITY_EN selects the parity build of DUT and model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux;
  localparam int N_CH = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int L   = N_CH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int L   = N_CH;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tdm_demux_if #(.N_CH(N_CH)) bus ();

  tdm_demux #(.N_CH(N_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is the list of bits collected since the marker.
  bit              m_locked;
  int              m_bits[$];
  logic [N_CH-1:0] m_q;
  bit              m_fv, m_se, m_pe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_bits.delete();
    m_q  = '0;
    m_fv = 1'b0;
    m_se = 1'b0;
    m_pe = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit f, input bit e, input bit c);
    bit err;
    int ones;
    err  = 1'b0;
    m_fv = 1'b0;
    m_pe = 1'b0;
    if (e) begin
      if (f) begin
        if (m_locked && m_bits.size() != 0) err = 1'b1;
        m_bits.delete();
        m_bits.push_back(int'(d));
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_bits.size() == 0) begin
          err      = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_bits.push_back(int'(d));
          if (m_bits.size() == L) begin
            ones = 0;
            foreach (m_bits[k]) ones += m_bits[k];
            if (PAR && (ones % 2) != 0) begin
              m_pe = 1'b1;
            end else begin
              for (int k = 0; k < N_CH; k++) m_q[k] = m_bits[k][0];
              m_fv = 1'b1;
            end
            m_bits.delete();
          end
        end
      end
    end
    if (err) m_se = 1'b1;
    else if (c) m_se = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},           32'(bus.q),           32'(m_q));
    chk({tag, ".sel"},         32'(bus.sel),         32'(m_bits.size()));
    chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(m_fv));
    chk({tag, ".sync_err"},    32'(bus.sync_err),    32'(m_se));
`ifdef TDM_DEMUX_PARITY_EN
    chk({tag, ".par_err"},     32'(bus.par_err),     32'(m_pe));
`endif
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input bit d, input bit f, input bit e, input bit c);
    bus.din     = d;
    bus.frame   = f;
    bus.en      = e;
    bus.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.din = 1'b0; bus.frame = 1'b0; bus.en = 1'b0; bus.clr_err = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       din, frame, en, clr;
    logic [3:0] q;
    int         sel;
    logic       fv, se;
  } vec_t;

  vec_t tv[39];
  int   gslot;
  bit   d, f, e, c;

  initial begin
    // --- Directed table (non-parity frame of 4 bits) ---
    for (int i = 0; i < 10; i++) tv[i] = '{i[0], 0, 1, 0, 4'h0, 0, 0, 0};
    tv[10] = '{1, 1, 1, 0, 4'h0, 1, 0, 0};
    tv[11] = '{0, 0, 1, 0, 4'h0, 2, 0, 0};
    tv[12] = '{1, 0, 1, 0, 4'h0, 3, 0, 0};
    tv[13] = '{1, 0, 1, 0, 4'hD, 0, 1, 0};
    tv[14] = '{0, 1, 1, 0, 4'hD, 1, 0, 0};
    tv[15] = '{1, 0, 1, 0, 4'hD, 2, 0, 0};
    tv[16] = '{0, 1, 1, 0, 4'hD, 1, 0, 1};
    tv[17] = '{1, 0, 1, 0, 4'hD, 2, 0, 1};
    tv[18] = '{1, 0, 1, 0, 4'hD, 3, 0, 1};
    tv[19] = '{0, 0, 1, 0, 4'h6, 0, 1, 1};
    tv[20] = '{0, 1, 1, 1, 4'h6, 1, 0, 0};
    tv[21] = '{1, 0, 1, 0, 4'h6, 2, 0, 0};
    tv[22] = '{0, 0, 1, 0, 4'h6, 3, 0, 0};
    tv[23] = '{0, 0, 1, 0, 4'h2, 0, 1, 0};
    tv[24] = '{1, 0, 1, 0, 4'h2, 0, 0, 1};
    tv[25] = '{1, 0, 1, 0, 4'h2, 0, 0, 1};
    tv[26] = '{1, 1, 1, 0, 4'h2, 1, 0, 1};
    tv[27] = '{0, 1, 1, 1, 4'h2, 1, 0, 1};
    tv[28] = '{0, 0, 1, 1, 4'h2, 2, 0, 0};
    tv[29] = '{1, 0, 1, 0, 4'h2, 3, 0, 0};
    tv[30] = '{0, 0, 1, 0, 4'h4, 0, 1, 0};
    tv[31] = '{1, 1, 1, 0, 4'h4, 1, 0, 0};
    tv[32] = '{0, 0, 0, 0, 4'h4, 1, 0, 0};
    tv[33] = '{1, 0, 1, 0, 4'h4, 2, 0, 0};
    tv[34] = '{0, 1, 0, 0, 4'h4, 2, 0, 0};
    tv[35] = '{0, 0, 1, 0, 4'h4, 3, 0, 0};
    tv[36] = '{1, 0, 0, 0, 4'h4, 3, 0, 0};
    tv[37] = '{0, 0, 1, 0, 4'h3, 0, 1, 0};
    tv[38] = '{0, 0, 0, 0, 4'h3, 0, 0, 0};

    do_reset();
    chk("reset.q",           32'(bus.q),           32'h0);
    chk("reset.sel",         32'(bus.sel),         32'h0);
    chk("reset.frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("reset.sync_err",    32'(bus.sync_err),    32'h0);

`ifndef TDM_DEMUX_PARITY_EN
    for (int i = 0; i < 39; i++) begin
      step(tv[i].din, tv[i].frame, tv[i].en, tv[i].clr);
      chk($sformatf("tv%0d.q", i),           32'(bus.q),           32'(tv[i].q));
      chk($sformatf("tv%0d.sel", i),         32'(bus.sel),         32'(tv[i].sel));
      chk($sformatf("tv%0d.frame_valid", i), 32'(bus.frame_valid), 32'(tv[i].fv));
      chk($sformatf("tv%0d.sync_err", i),    32'(bus.sync_err),    32'(tv[i].se));
    end

    // --- Async reset in the middle of a frame ---
    do_reset();
    step(1, 1, 1, 0); step(0, 0, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    chk("arst.pre_q", 32'(bus.q), 32'hD);
    step(0, 1, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    chk("arst.pre_sel", 32'(bus.sel), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst.q",   32'(bus.q),   32'h0);
    chk("arst.sel", 32'(bus.sel), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    // Unmarked bit must be ignored quietly: proves the FSM is back in HUNT.
    step(1, 0, 1, 0);
    chk("arst.hunt_sel",  32'(bus.sel),      32'h0);
    chk("arst.hunt_serr", 32'(bus.sync_err), 32'h0);
`else
    // --- Parity: good frame then same data with bad parity ---
    step(1, 1, 1, 0); check_model("par1");
    step(0, 0, 1, 0); check_model("par1");
    step(1, 0, 1, 0); check_model("par1");
    step(1, 0, 1, 0); check_model("par1");
    step(1, 0, 1, 0);
    chk("par.good_q",  32'(bus.q),           32'hD);
    chk("par.good_fv", 32'(bus.frame_valid), 32'h1);
    chk("par.good_pe", 32'(bus.par_err),     32'h0);
    step(1, 1, 1, 0); step(0, 0, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("par.bad_q",  32'(bus.q),           32'hD);
    chk("par.bad_fv", 32'(bus.frame_valid), 32'h0);
    chk("par.bad_pe", 32'(bus.par_err),     32'h1);
    step(0, 1, 1, 0);
    chk("par.pe_pulse", 32'(bus.par_err), 32'h0);
`endif

    // --- Randomized traffic against the frame model ---
    do_reset();
    gslot = 0;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      d = $urandom_range(0, 1);
      f = (gslot == 0);
      if ($urandom_range(0, 29) == 0) f = ~f;
      c = ($urandom_range(0, 19) == 0);
      if (e) gslot = (gslot + 1) % L;
      step(d, f, e, c);
      model_step(d, f, e, c);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
